tdc_sequencer: RTL and testbench
================================

TDC_SEQUENCER -- requirements
Module: tdc_sequencer

Interface
REQ-001 Parameter BOOT_CYCLES, default 100000, cycles tdc_enable is held high before soft reset (2 ms at 50 MHz, above the 1.7 ms TDC boot time).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum wait for tdc_done after a start pulse.
REQ-003 Parameter CH_MASK, default 6'b111111, channels included in the round-robin.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rx_data  in  8  UART command byte (ASCII).
REQ-007 new_rx_data  in  1  one-cycle strobe; rx_data valid.
REQ-008 tdc_done  in  6  per-channel measurement-complete, bit n = channel n.
REQ-009 tdc_enable  out  1  common TDC enable level, shared by all six channels.
REQ-010 soft_reset  out  6  per-channel soft-reset pulse.
REQ-011 start  out  6  per-channel one-cycle measurement start.
REQ-012 cur_ch  out  3  channel index currently owned (0-5).
REQ-013 meas_valid  out  1  one-cycle pulse: cur_ch finished.
REQ-014 timeout_err  out  1  one-cycle pulse: cur_ch timed out.
REQ-015 pause  out  1  pause level.
REQ-016 go_home  out  1  go-home level.

Function
REQ-017 All outputs SHALL be driven directly from flip-flops.
REQ-018 States: OFF, BOOT, SRESET, SELECT, START, WAIT; 3-bit encoding; an illegal state SHALL return to OFF on the next cycle.
REQ-019 OFF: tdc_enable=0; new_rx_data with "d" -> BOOT, 20-bit counter cleared.
REQ-020 BOOT: tdc_enable=1; counter increments; at counter==BOOT_CYCLES-1 -> SRESET.
REQ-021 SRESET: soft_reset=CH_MASK for exactly one cycle -> SELECT; cur_ch set to 5 so the first grant goes to the lowest enabled channel.
REQ-022 SELECT: pause=1 -> hold; else cur_ch = next enabled channel after cur_ch, ascending, wrapping 5->0 -> START; CH_MASK==0 -> hold in SELECT permanently.
REQ-023 START: start[cur_ch]=1 for one cycle, all other start bits 0; counter cleared -> WAIT.
REQ-024 WAIT: tdc_done[cur_ch]=1 -> meas_valid pulse -> SELECT; else counter==TIMEOUT_CYCLES-1 -> timeout_err pulse -> SELECT; else counter increments.
REQ-025 WAIT: done and timeout in the same cycle -> done wins; tdc_done on any channel other than cur_ch SHALL be ignored.
REQ-026 tdc_enable SHALL be 1 in every state except OFF.
REQ-027 Commands are decoded only when new_rx_data=1; unknown bytes are ignored.
REQ-028 "x": from any state -> OFF next cycle; tdc_enable=0; any in-flight measurement is abandoned with no meas_valid or timeout_err pulse.
REQ-029 "d" outside OFF SHALL be ignored (no re-boot).
REQ-030 "s" sets pause; "p" clears pause and go_home; "h" sets go_home; levels persist until changed or reset.
REQ-031 Pause affects only SELECT: START/WAIT already in progress SHALL complete normally.
REQ-032 Repeating a command in consecutive cycles SHALL have the same effect as issuing it once; commands never stall the FSM.

Reset
REQ-033 rst=1 SHALL asynchronously force state=OFF, counter=0, cur_ch=0, tdc_enable=0, soft_reset=0, start=0, meas_valid=0, timeout_err=0, pause=0, go_home=0.
REQ-034 Reset asserted mid-BOOT or mid-WAIT SHALL take effect without waiting for a clock edge; after release the block waits in OFF for "d".

Verification (BOOT_CYCLES=4, TIMEOUT_CYCLES=8)
REQ-035 "d" in OFF -> tdc_enable=1 next cycle, soft_reset=6'h3F for exactly 1 cycle after 4 BOOT cycles, then start=6'h01.
REQ-036 tdc_done=6'h01 two cycles after start -> meas_valid pulse; next starts are 6'h02, 6'h04 ... 6'h20, then 6'h01 (wrap).
REQ-037 CH_MASK=6'b100100, no done -> start on 6'h04, timeout_err after 8 WAIT cycles, then 6'h20, then 6'h04.
REQ-038 "s" during WAIT ch1, then done -> meas_valid, no further start; "p" -> start=6'h04 follows.
REQ-039 tdc_done[cur_ch] in the last timeout cycle -> meas_valid only; done on another channel -> no effect.
REQ-040 "x" mid-WAIT -> OFF, tdc_enable=0, no pulses; rst mid-BOOT -> all outputs 0 immediately; "h" -> go_home=1, "p" -> 0.

Source files
------------

// File: rtl/tdc_sequencer.sv
// Boot, soft-reset and round-robin measurement sequencer for a six-channel TDC,
// commanded by single ASCII bytes arriving from a UART receiver.
module tdc_sequencer #(
  parameter int          BOOT_CYCLES    = 100000,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [5:0]  CH_MASK        = 6'b111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  input  logic [5:0] tdc_done,
  output logic       tdc_enable,
  output logic [5:0] soft_reset,
  output logic [5:0] start,
  output logic [2:0] cur_ch,
  output logic       meas_valid,
  output logic       timeout_err,
  output logic       pause,
  output logic       go_home
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BOOT   = 3'd1,
    ST_SRESET = 3'd2,
    ST_SELECT = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5
  } state_t;

  localparam logic [19:0] BOOT_LAST    = 20'(BOOT_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [19:0] count_reg, count_next;
  logic [2:0]  cur_ch_reg, cur_ch_next;

  logic       tdc_enable_reg, tdc_enable_next;
  logic [5:0] soft_reset_reg, soft_reset_next;
  logic [5:0] start_reg, start_next;
  logic       meas_valid_reg, meas_valid_next;
  logic       timeout_err_reg, timeout_err_next;
  logic       pause_reg, pause_next;
  logic       go_home_reg, go_home_next;

  logic       cmd_d, cmd_x, cmd_s, cmd_p, cmd_h;
  logic       done_hit;
  logic [2:0] next_ch;
  logic [5:0] start_onehot;

  assign cmd_d = new_rx_data && (rx_data == 8'h64);
  assign cmd_x = new_rx_data && (rx_data == 8'h78);
  assign cmd_s = new_rx_data && (rx_data == 8'h73);
  assign cmd_p = new_rx_data && (rx_data == 8'h70);
  assign cmd_h = new_rx_data && (rx_data == 8'h68);

  // Only the owned channel's done bit matters; the others are ignored.
  assign done_hit = tdc_done[cur_ch_reg];

  // First enabled channel strictly after cur_ch, ascending with wrap 5 -> 0.
  always_comb begin
    int          c;
    logic        found;
    logic [2:0]  cand;
    next_ch = cur_ch_reg;
    found   = 1'b0;
    c       = 0;
    cand    = 3'd0;
    for (int i = 1; i <= 6; i++) begin
      c = int'(cur_ch_reg) + i;
      if (c >= 6) c = c - 6;
      cand = 3'(c);
      if (!found && CH_MASK[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_OFF;
      count_reg  <= 20'd0;
      cur_ch_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      cur_ch_reg <= cur_ch_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    cur_ch_next = cur_ch_reg;
    case (state_reg)
      ST_OFF: begin
        if (cmd_d) begin
          state_next = ST_BOOT;
          count_next = 20'd0;
        end
      end
      ST_BOOT: begin
        if (count_reg == BOOT_LAST) begin
          state_next = ST_SRESET;
          count_next = 20'd0;
        end else begin
          count_next = count_reg + 20'd1;
        end
      end
      ST_SRESET: begin
        state_next  = ST_SELECT;
        cur_ch_next = 3'd5;
      end
      ST_SELECT: begin
        // An empty mask leaves nothing to grant, so SELECT is held forever.
        if (!pause_reg && (CH_MASK != 6'd0)) begin
          cur_ch_next = next_ch;
          state_next  = ST_START;
        end
      end
      ST_START: begin
        count_next = 20'd0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_hit || (count_reg == TIMEOUT_LAST)) begin
          state_next = ST_SELECT;
        end else begin
          count_next = count_reg + 20'd1;
        end
      end
      default: state_next = ST_OFF;
    endcase
    if (cmd_x) begin
      state_next = ST_OFF;
      count_next = 20'd0;
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_start
    assign start_onehot[gi] = (cur_ch_next == 3'(gi));
  end

  // Outputs are computed from the upcoming state so each register lines up with it.
  always_comb begin
    tdc_enable_next  = (state_next != ST_OFF);
    soft_reset_next  = (state_next == ST_SRESET) ? CH_MASK : 6'd0;
    start_next       = (state_next == ST_START) ? start_onehot : 6'd0;
    meas_valid_next  = (state_reg == ST_WAIT) && done_hit && !cmd_x;
    timeout_err_next = (state_reg == ST_WAIT) && !done_hit &&
                       (count_reg == TIMEOUT_LAST) && !cmd_x;
    pause_next       = pause_reg;
    go_home_next     = go_home_reg;
    if (cmd_s) pause_next = 1'b1;
    if (cmd_h) go_home_next = 1'b1;
    if (cmd_p) begin
      pause_next   = 1'b0;
      go_home_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdc_enable_reg  <= 1'b0;
      soft_reset_reg  <= 6'd0;
      start_reg       <= 6'd0;
      meas_valid_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      pause_reg       <= 1'b0;
      go_home_reg     <= 1'b0;
    end else begin
      tdc_enable_reg  <= tdc_enable_next;
      soft_reset_reg  <= soft_reset_next;
      start_reg       <= start_next;
      meas_valid_reg  <= meas_valid_next;
      timeout_err_reg <= timeout_err_next;
      pause_reg       <= pause_next;
      go_home_reg     <= go_home_next;
    end
  end

  assign tdc_enable  = tdc_enable_reg;
  assign soft_reset  = soft_reset_reg;
  assign start       = start_reg;
  assign cur_ch      = cur_ch_reg;
  assign meas_valid  = meas_valid_reg;
  assign timeout_err = timeout_err_reg;
  assign pause       = pause_reg;
  assign go_home     = go_home_reg;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed bench: one full-mask sequencer (a) and one sparse-mask sequencer (b)
// sharing clock and reset, with expected values worked out by hand.
module tb_tdc_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] rx_a, rx_b;
  logic       new_a, new_b;
  logic [5:0] done_a, done_b;

  logic       en_a, en_b;
  logic [5:0] soft_a, soft_b;
  logic [5:0] start_a, start_b;
  logic [2:0] cur_a, cur_b;
  logic       meas_a, meas_b;
  logic       tmo_a, tmo_b;
  logic       pause_a, pause_b;
  logic       home_a, home_b;

  int checks = 0;
  int errors = 0;

  tdc_sequencer #(.BOOT_CYCLES(4), .TIMEOUT_CYCLES(8), .CH_MASK(6'b111111)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_a), .new_rx_data(new_a), .tdc_done(done_a),
    .tdc_enable(en_a), .soft_reset(soft_a), .start(start_a), .cur_ch(cur_a),
    .meas_valid(meas_a), .timeout_err(tmo_a), .pause(pause_a), .go_home(home_a)
  );

  tdc_sequencer #(.BOOT_CYCLES(4), .TIMEOUT_CYCLES(8), .CH_MASK(6'b100100)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_b), .new_rx_data(new_b), .tdc_done(done_b),
    .tdc_enable(en_b), .soft_reset(soft_b), .start(start_b), .cur_ch(cur_b),
    .meas_valid(meas_b), .timeout_err(tmo_b), .pause(pause_b), .go_home(home_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd_a(input logic [7:0] b);
    rx_a  = b;
    new_a = 1'b1;
    step();
    new_a = 1'b0;
  endtask

  task automatic cmd_b(input logic [7:0] b);
    rx_b  = b;
    new_b = 1'b1;
    step();
    new_b = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0;
    rx_a = 8'h00; rx_b = 8'h00; new_a = 1'b0; new_b = 1'b0;
    done_a = 6'd0; done_b = 6'd0;

    #1 rst = 1'b1;
    #2;
    chk("rst_en", 32'(en_a), 0);
    chk("rst_soft", 32'(soft_a), 0);
    chk("rst_start", 32'(start_a), 0);
    chk("rst_cur", 32'(cur_a), 0);
    chk("rst_pulses", 32'({meas_a, tmo_a, pause_a, home_a}), 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("off_idle_en", 32'(en_a), 0);
    $display("reset released, both sequencers idle in OFF");

    // Boot sequence on a
    cmd_a("d");
    chk("boot_en", 32'(en_a), 1);
    chk("boot_soft0", 32'(soft_a), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("boot_soft_hold", 32'(soft_a), 0);
    end
    step();
    chk("sreset_pulse", 32'(soft_a), 32'h3F);
    chk("sreset_start", 32'(start_a), 0);
    step();
    chk("sreset_end", 32'(soft_a), 0);
    chk("select_start", 32'(start_a), 0);
    step();
    chk("first_start", 32'(start_a), 32'h01);
    chk("first_cur", 32'(cur_a), 0);
    $display("a: boot done, soft_reset=3f once, first start=01");

    // Round robin with done two cycles after each start
    for (int k = 0; k < 6; k++) begin
      step();
      chk("wait_start_low", 32'(start_a), 0);
      done_a = 6'(1 << k);
      step();
      chk("rr_meas", 32'(meas_a), 1);
      chk("rr_tmo", 32'(tmo_a), 0);
      done_a = 6'd0;
      step();
      chk("rr_meas_end", 32'(meas_a), 0);
      chk("rr_next_start", 32'(start_a), 32'(1 << ((k + 1) % 6)));
      chk("rr_next_cur", 32'(cur_a), 32'((k + 1) % 6));
      $display("a: ch%0d done, next start=%0h", k, start_a);
    end

    // Pause during WAIT on ch1
    step();
    done_a = 6'h01;
    step();
    done_a = 6'd0;
    step();
    chk("p_start_ch1", 32'(start_a), 32'h02);
    step();
    cmd_a("s");
    chk("pause_set", 32'(pause_a), 1);
    done_a = 6'h02;
    step();
    chk("pause_meas", 32'(meas_a), 1);
    done_a = 6'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("paused_no_start", 32'(start_a), 0);
      chk("paused_cur", 32'(cur_a), 1);
    end
    cmd_a("p");
    chk("pause_clr", 32'(pause_a), 0);
    chk("pause_clr_start", 32'(start_a), 0);
    step();
    chk("resume_start", 32'(start_a), 32'h04);
    chk("resume_cur", 32'(cur_a), 2);
    $display("a: paused after ch1, resumed with start=%0h", start_a);

    // Repeated go-home command, then clear
    rx_a = "h"; new_a = 1'b1;
    step();
    chk("home_set1", 32'(home_a), 1);
    step();
    new_a = 1'b0;
    chk("home_set2", 32'(home_a), 1);
    chk("home_en", 32'(en_a), 1);
    cmd_a("p");
    chk("home_clr", 32'(home_a), 0);

    // Abort mid-WAIT with a coincident done on the owned channel
    done_a = 6'h04;
    cmd_a("x");
    done_a = 6'd0;
    chk("abort_en", 32'(en_a), 0);
    chk("abort_meas", 32'(meas_a), 0);
    chk("abort_tmo", 32'(tmo_a), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("off_quiet", 32'({en_a, soft_a, start_a, meas_a, tmo_a}), 0);
    end
    $display("a: x abort mid-WAIT, silent in OFF");

    // Sparse mask on b: timeouts and foreign done bits
    cmd_b("d");
    chk("b_boot_en", 32'(en_b), 1);
    repeat (3) step();
    step();
    chk("b_sreset", 32'(soft_b), 32'h24);
    step();
    step();
    chk("b_first_start", 32'(start_b), 32'h04);
    chk("b_first_cur", 32'(cur_b), 2);
    done_b = 6'h3B;
    for (int i = 7; i <= 14; i++) begin
      rx_b  = "d";
      new_b = (i == 9);
      step();
      new_b = 1'b0;
      chk("b_wait_no_tmo", 32'(tmo_b), 0);
      chk("b_wait_no_meas", 32'(meas_b), 0);
      chk("b_no_reboot", 32'(soft_b), 0);
    end
    step();
    chk("b_tmo1", 32'(tmo_b), 1);
    chk("b_tmo1_meas", 32'(meas_b), 0);
    done_b = 6'd0;
    step();
    chk("b_start_ch5", 32'(start_b), 32'h20);
    chk("b_cur5", 32'(cur_b), 5);
    chk("b_tmo1_end", 32'(tmo_b), 0);
    $display("b: ch2 timed out, start=%0h", start_b);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("b_wait5", 32'(tmo_b), 0);
    end
    step();
    chk("b_tmo2", 32'(tmo_b), 1);
    step();
    chk("b_wrap_start", 32'(start_b), 32'h04);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("b_wait2", 32'({meas_b, tmo_b}), 0);
    end
    done_b = 6'h04;
    step();
    chk("b_last_meas", 32'(meas_b), 1);
    chk("b_last_tmo", 32'(tmo_b), 0);
    done_b = 6'd0;
    step();
    chk("b_after_start", 32'(start_b), 32'h20);
    chk("b_after_meas", 32'(meas_b), 0);
    $display("b: done in last timeout cycle gave meas_valid only");

    // Asynchronous reset mid-BOOT (a) and mid-WAIT (b)
    cmd_a("h");
    cmd_a("d");
    chk("r_home", 32'(home_a), 1);
    chk("r_boot_en", 32'(en_a), 1);
    step();
    rst = 1'b1;
    #2;
    chk("ar_a_en", 32'(en_a), 0);
    chk("ar_a_home", 32'(home_a), 0);
    chk("ar_a_outs", 32'({soft_a, start_a, cur_a, meas_a, tmo_a, pause_a}), 0);
    chk("ar_b_en", 32'(en_b), 0);
    chk("ar_b_cur", 32'(cur_b), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_off", 32'({en_a, soft_a, start_a, en_b, start_b}), 0);
    end
    $display("async reset mid-BOOT/mid-WAIT cleared all outputs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
